// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between the execute datapath (port 0) and the branch unit (port 1).
// Tie policy is fixed priority to port 0 unless ALU_ARB_RR_EN is defined, which enables round-robin.
module alu_share_arbiter #(
  parameter int              WIDTH   = 32,
  parameter int              OP_W    = 4,
  parameter logic [OP_W-1:0] IDLE_OP = 4'b1111
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OP_W-1:0]  req0_op,
  input  logic [OP_W-1:0]  req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OP_W-1:0]  alu_op,
  input  logic [WIDTH-1:0] alu_c,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_c,
  output logic             rsp_zero
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] alu_a_q, alu_b_q, rsp_c_q;
  logic [OP_W-1:0]  alu_op_q;
  logic             gnt_id_q, rsp_id_q, rsp_zero_q;
  logic             tie_winner, gnt_sel, accept;

`ifdef ALU_ARB_RR_EN
  logic last_gnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt_q <= 1'b1;
    end else if (accept) begin
      last_gnt_q <= gnt_sel;
    end
  end

  assign tie_winner = ~last_gnt_q;
`else
  assign tie_winner = 1'b0;
`endif

  // With a single valid port the grant simply follows it; only a tie consults the policy.
  assign gnt_sel = (req0_valid && req1_valid) ? tie_winner : ~req0_valid;
  assign accept  = (state_q == S_IDLE) && (req0_valid || req1_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req0_valid || req1_valid) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    case (state_q)
      S_IDLE: begin
        req0_ready = req0_valid && !gnt_sel;
        req1_ready = req1_valid && gnt_sel;
      end
      S_RESP:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= IDLE_OP;
      gnt_id_q   <= 1'b0;
      rsp_c_q    <= '0;
      rsp_zero_q <= 1'b0;
      rsp_id_q   <= 1'b0;
    end else begin
      if (accept) begin
        alu_a_q  <= gnt_sel ? req1_a : req0_a;
        alu_b_q  <= gnt_sel ? req1_b : req0_b;
        alu_op_q <= gnt_sel ? req1_op : req0_op;
        gnt_id_q <= gnt_sel;
      end
      // The ALU result is only trusted during the single EXEC cycle.
      if (state_q == S_EXEC) begin
        rsp_c_q    <= alu_c;
        rsp_zero_q <= alu_zero;
        rsp_id_q   <= gnt_id_q;
        alu_op_q   <= IDLE_OP;
      end
    end
  end

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_op   = alu_op_q;
  assign rsp_c    = rsp_c_q;
  assign rsp_zero = rsp_zero_q;
  assign rsp_id   = rsp_id_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized and directed bench for alu_share_arbiter against a transaction-level model,
// with a small behavioural ALU standing in for the real one.
module tb_alu_share_arbiter;
  localparam int         WIDTH   = 32;
  localparam int         OP_W    = 4;
  localparam logic [3:0] IDLE_OP = 4'b1111;

  logic             clk, rst;
  logic             req0_valid, req1_valid, req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [OP_W-1:0]  req0_op, req1_op;
  logic [WIDTH-1:0] alu_a, alu_b, alu_c;
  logic [OP_W-1:0]  alu_op;
  logic             alu_zero;
  logic             rsp_valid, rsp_ready, rsp_id, rsp_zero;
  logic [WIDTH-1:0] rsp_c;

  alu_share_arbiter #(.WIDTH(WIDTH), .OP_W(OP_W), .IDLE_OP(IDLE_OP)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_op(req0_op), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_c(alu_c), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_c(rsp_c), .rsp_zero(rsp_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] alu_fn(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b,
                                              logic [OP_W-1:0] op);
    case (op)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0010: return a & b;
      4'b0011: return a | b;
      default: return a;
    endcase
  endfunction

  always_comb begin
    alu_c    = alu_fn(alu_a, alu_b, alu_op);
    alu_zero = (alu_c == '0);
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Model: m_busy counts 0 = free, 1 = operation on ALU, 2 = response waiting.
  int               m_busy;
  bit               m_last;
  logic [WIDTH-1:0] m_a, m_b, m_c;
  logic [OP_W-1:0]  m_op;
  bit               m_id, m_zero;
  int               ids[$];

  function automatic bit pick(bit v0, bit v1);
    if (v0 && v1) begin
`ifdef ALU_ARB_RR_EN
      return !m_last;
`else
      return 1'b0;
`endif
    end
    return v0 ? 1'b0 : 1'b1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_last = 1'b1; m_a = '0; m_b = '0; m_op = IDLE_OP; m_id = 1'b0;
  endtask

  // Inputs are already applied; check this cycle, advance the model, cross one edge.
  task automatic tick();
    bit g, e0, e1;
    int nb;
    #1;
    g = pick(req0_valid, req1_valid);
    e0 = (m_busy == 0) && req0_valid && !g;
    e1 = (m_busy == 0) && req1_valid && g;
    chk("req0_ready", req0_ready, e0);
    chk("req1_ready", req1_ready, e1);
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    chk("alu_op", alu_op, (m_busy == 1) ? m_op : IDLE_OP);
    chk("rsp_valid", rsp_valid, m_busy == 2);
    if (m_busy == 2) begin
      chk("rsp_id", rsp_id, m_id);
      chk("rsp_c", rsp_c, m_c);
      chk("rsp_zero", rsp_zero, m_zero);
    end
    nb = m_busy;
    if (m_busy == 0 && (e0 || e1)) begin
      m_a = g ? req1_a : req0_a;
      m_b = g ? req1_b : req0_b;
      m_op = g ? req1_op : req0_op;
      m_id = g; m_last = g; nb = 1;
    end else if (m_busy == 1) begin
      m_c = alu_fn(m_a, m_b, m_op); m_zero = (m_c == '0); nb = 2;
    end else if (m_busy == 2 && rsp_ready) begin
      ids.push_back(int'(rsp_id));
      $display("rsp id=%0d c=%08h zero=%0d", rsp_id, rsp_c, rsp_zero);
      nb = 0;
    end
    @(posedge clk);
    #1;
    m_busy = nb;
  endtask

  task automatic rand_ops();
    req0_a = $urandom; req0_b = $urandom; req0_op = 4'($urandom_range(0, 4));
    req1_a = $urandom; req1_b = $urandom; req1_op = 4'($urandom_range(0, 4));
    if ($urandom_range(0, 7) == 0) req0_b = req0_a;
  endtask

  task automatic drain(input int n);
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    repeat (n) tick();
  endtask

  int tie_exp[4];

  initial begin
    rst = 1; req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0; req0_op = 0; req1_op = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_op", alu_op, IDLE_OP);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_c", rsp_c, 0);
    model_reset();
    rst = 0;

    // Port 0: 5 + 7
    req0_valid = 1; req0_a = 5; req0_b = 7; req0_op = 4'b0000;
    tick();
    req0_valid = 0;
    tick();
    chk("t1_rsp_c", rsp_c, 12);
    chk("t1_rsp_zero", rsp_zero, 0);
    chk("t1_rsp_id", rsp_id, 0);
    rsp_ready = 1;
    tick();

    // Port 1: 9 - 9
    req1_valid = 1; req1_a = 9; req1_b = 9; req1_op = 4'b0001;
    tick();
    req1_valid = 0;
    tick();
    chk("t2_rsp_c", rsp_c, 0);
    chk("t2_rsp_zero", rsp_zero, 1);
    chk("t2_rsp_id", rsp_id, 1);
    tick();

    // Both ports tie for four operations
`ifdef ALU_ARB_RR_EN
    tie_exp = '{0, 1, 0, 1};
`else
    tie_exp = '{0, 0, 0, 0};
`endif
    req0_valid = 1; req1_valid = 1; rsp_ready = 1;
    for (int i = 0; i < 40 && ids.size() < 6; i++) begin
      rand_ops();
      tick();
    end
    chk("tie_count", ids.size(), 6);
    for (int i = 0; i < 4; i++)
      if (ids.size() > i + 2) chk("tie_id", ids[i+2], tie_exp[i]);
    drain(4);

    // Back-pressure in RESP with a request waiting
    rand_ops(); req1_valid = 1; rsp_ready = 0;
    repeat (5) tick();
    rsp_ready = 1;
    tick();
    tick();
    req1_valid = 0;
    drain(4);

    // One-cycle request during RESP must be ignored
    req0_valid = 1; rsp_ready = 0;
    tick();
    req0_valid = 0;
    tick();
    tick();
    req0_valid = 1;
    tick();
    drain(4);

    // Reset during EXEC
    rand_ops(); req0_valid = 1;
    tick();
    req0_valid = 0;
    rst = 1;
    #1;
    chk("mid_rst_alu_a", alu_a, 0);
    chk("mid_rst_alu_op", alu_op, IDLE_OP);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_rsp_c", rsp_c, 0);
    chk("mid_rst_req0_ready", req0_ready, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
    drain(3);
    rand_ops(); req0_valid = 1;
    tick();
    drain(4);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rand_ops();
      req0_valid = ($urandom_range(0, 1) == 1);
      req1_valid = ($urandom_range(0, 1) == 1);
      rsp_ready  = ($urandom_range(0, 9) < 7);
      tick();
    end
    drain(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Two-port arbiter that shares the single ALU between two requesters: port 0 is the main execute datapath and port 1 is the branch/compare unit. It accepts one operation at a time over a valid/ready handshake and registers the operands onto the ALU input bus. It captures the ALU's `C` and `Zero` into a response register and returns them with the requester id. It sits between the requesters and the ALU instance; the ALU itself stays purely combinational.

## Interface
- `WIDTH`, 32, operand/result width
- `OP_W`, 4, ALUop width
- `IDLE_OP`, 4'b1111, ALUop driven when no operation is in flight (ALU default: pass A)

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous and active-high
- `req0_valid`, `req1_valid`  in  1  request present on port 0 / 1
- `req0_ready`, `req1_ready`  out  1  port accepted this cycle when valid & ready
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  WIDTH  operands
- `req0_op`, `req1_op`  in  OP_W  ALUop
- `alu_a`, `alu_b`  out  WIDTH  registered operands to the ALU
- `alu_op`  out  OP_W  registered ALUop to the ALU
- `alu_c`  in  WIDTH  ALU result
- `alu_zero`  in  1  ALU Zero flag
- `rsp_valid`  out  1  response available
- `rsp_ready`  in  1  consumer takes the response when valid & ready
- `rsp_id`  out  1  0 = port 0, 1 = port 1
- `rsp_c`  out  WIDTH  captured result
- `rsp_zero`  out  1  captured Zero

## Operation
FSM with three states; reset state is IDLE.

- **IDLE**
  - `req_ready` is asserted only to the granted port, and only when that port is valid; the other port's ready is 0.
  - On accept, latch a/b/op into `alu_a`/`alu_b`/`alu_op` and the id into `gnt_id`, then go to EXEC.
  - If neither port is valid, stay in IDLE.
- **EXEC**
  - The ALU evaluates the registered operands for exactly one cycle.
  - At the clock edge, capture `alu_c` into `rsp_c`, `alu_zero` into `rsp_zero` and `gnt_id` into `rsp_id`.
  - Return `alu_op` to `IDLE_OP` and go to RESP. `alu_a`/`alu_b` keep their values.
- **RESP**
  - `rsp_valid` = 1.
  - When `rsp_ready` = 1, go to IDLE; otherwise hold.
  - All `rsp_*` outputs stay stable while waiting.
  - Both `req_ready` outputs are 0.

Arbitration:
- If only one port is valid, it is granted.
- If both are valid, the grant follows the arbitration policy (see Configuration).
- The `last_gnt` register updates only on accept; its reset value is 1, so port 0 wins the first tie.

Other rules:
- No arithmetic is done in this block; widths pass through unchanged.
- A requester may drop valid before acceptance. No state changes in that case.
- A request that arrives in EXEC or RESP waits in IDLE arbitration.

## Timing
- Accept at edge N (end of IDLE cycle) → ALU inputs valid during cycle N+1.
- Response registered at edge N+1 → `rsp_valid` = 1 from cycle N+2.
- Minimum latency from accept to response: 2 cycles.
- Throughput: one operation per 3 cycles with `rsp_ready` held high.
- `req_ready` is combinational from the state, `req_valid` and `last_gnt`. There is no combinational path from `rsp_ready` to `req_ready`.
- Reset values: state = IDLE, `req0_ready` = `req1_ready` = 0, `alu_a` = `alu_b` = 0, `alu_op` = `IDLE_OP`, `rsp_valid` = 0, `rsp_id` = 0, `rsp_c` = 0, `rsp_zero` = 0, `last_gnt` = 1.
- Reset asserted mid-operation (EXEC or RESP) drops the in-flight operation immediately. No response is produced.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin. On a tie, grant the port ≠ `last_gnt`.
- `ALU_ARB_RR_EN` undefined: fixed priority. Port 0 always wins a tie, and the `last_gnt` register is removed.

## Test plan
- Reset, then req0: a=5, b=7, op=0000 accepted at edge N → `alu_a`=5, `alu_b`=7, `alu_op`=0000 in N+1; at N+2 `rsp_valid`=1, `rsp_c`=12, `rsp_zero`=0, `rsp_id`=0.
- req1: a=9, b=9, op=0001 → `rsp_c`=0, `rsp_zero`=1, `rsp_id`=1.
- Both ports held valid for 4 operations, `rsp_ready`=1:
  - with `ALU_ARB_RR_EN`: id sequence 0,1,0,1;
  - without it: 0,0,0,0.
- `rsp_ready` held 0 for 3 cycles in RESP → `rsp_*` stable, both `req_ready`=0; raise `rsp_ready` → IDLE next cycle, a pending request is accepted that cycle.
- Assert `rst` during EXEC → next cycle all outputs are at their reset values; no `rsp_valid` pulse occurs; a new request afterwards completes normally.
- Assert req0_valid for one cycle while in RESP, then deassert → request never accepted, no extra response.
